// File: rtl/softmax_norm_if.sv
// Handshake bundle for softmax_norm: element vector plus reduced sum in,
// normalised fixed-point fractions out.
interface softmax_norm_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 15
);
  localparam int OUT_W = FRAC_BITS + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_vec;
  logic [DATA_WIDTH-1:0]         in_sum;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_INPUTS*OUT_W-1:0]   out_vec;
  logic                          div_zero;

  modport master (
    output in_valid, in_vec, in_sum, out_ready,
    input  in_ready, out_valid, out_vec, div_zero
  );

  modport slave (
    input  in_valid, in_vec, in_sum, out_ready,
    output in_ready, out_valid, out_vec, div_zero
  );
endinterface

// File: rtl/softmax_norm.sv
// Softmax normalisation: one shared restoring divider computes x_i*2^FRAC_BITS/sum per lane.
// Define SOFTMAX_NORM_ROUND_EN for round-to-nearest quotients instead of floor.
module softmax_norm #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 15
) (
  input  logic           clk,
  input  logic           rst,
  softmax_norm_if.slave  bus
);
  localparam int OUT_W = FRAC_BITS + 1;
  localparam int ITER  = DATA_WIDTH + FRAC_BITS;
  localparam int ITW   = $clog2(ITER);
  localparam int EW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  state_e                          state_q, state_d;
  logic [EW-1:0]                   elem_q, elem_d;
  logic [ITW-1:0]                  iter_q, iter_d;
  logic [DATA_WIDTH-1:0]           sum_q, sum_d;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] vec_q, vec_d;
  logic [ITER-1:0]                 dividend_q, dividend_d;
  logic [DATA_WIDTH-1:0]           rem_q, rem_d;
  logic [ITER-2:0]                 quo_q, quo_d;
  logic [NUM_INPUTS*OUT_W-1:0]     out_vec_q, out_vec_d;
  logic                            div_zero_q, div_zero_d;
  logic                            out_valid_q, out_valid_d;
  logic                            in_ready_q, in_ready_d;

  logic [DATA_WIDTH-1:0] in_lane  [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] vec_lane [NUM_INPUTS];

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
    assign in_lane[gi]  = bus.in_vec[gi*DATA_WIDTH +: DATA_WIDTH];
    assign vec_lane[gi] = vec_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [DATA_WIDTH:0]   rem_shift;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] rem_new;
  logic [ITER-1:0]       quo_new;
  logic [OUT_W-1:0]      lane_sat;
  logic [OUT_W-1:0]      lane_val;
  logic                  last_iter;
  logic                  last_elem;
  logic                  accept;
  logic [EW-1:0]         elem_inc;

  assign rem_shift = {rem_q, dividend_q[ITER-1]};
  assign q_bit     = (rem_shift >= {1'b0, sum_q});
  assign rem_new   = q_bit ? DATA_WIDTH'(rem_shift - {1'b0, sum_q}) : rem_shift[DATA_WIDTH-1:0];
  assign quo_new   = {quo_q, q_bit};
  assign lane_sat  = (|quo_new[ITER-1:OUT_W]) ? OUT_MAX : quo_new[OUT_W-1:0];

`ifdef SOFTMAX_NORM_ROUND_EN
  assign lane_val = (({rem_new, 1'b0} >= {1'b0, sum_q}) && (lane_sat != OUT_MAX))
                    ? lane_sat + OUT_W'(1) : lane_sat;
`else
  assign lane_val = lane_sat;
`endif

  assign last_iter = (iter_q == ITW'(ITER - 1));
  assign last_elem = (elem_q == EW'(NUM_INPUTS - 1));
  assign accept    = bus.in_valid && in_ready_q;
  assign elem_inc  = elem_q + EW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      iter_q      <= '0;
      sum_q       <= '0;
      vec_q       <= '0;
      dividend_q  <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      out_vec_q   <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      iter_q      <= iter_d;
      sum_q       <= sum_d;
      vec_q       <= vec_d;
      dividend_q  <= dividend_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      out_vec_q   <= out_vec_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (bus.in_sum == '0) ? DONE : DIV;
      DIV:  if (last_iter && last_elem) state_d = DONE;
      DONE: if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    elem_d      = elem_q;
    iter_d      = iter_q;
    sum_d       = sum_q;
    vec_d       = vec_q;
    dividend_d  = dividend_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    out_vec_d   = out_vec_q;
    div_zero_d  = div_zero_q;
    out_valid_d = 1'b0;
    in_ready_d  = (state_d == IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          vec_d  = bus.in_vec;
          sum_d  = bus.in_sum;
          elem_d = '0;
          iter_d = '0;
          rem_d  = '0;
          quo_d  = '0;
          dividend_d = {in_lane[0], {FRAC_BITS{1'b0}}};
          if (bus.in_sum == '0) begin
            out_vec_d  = '0;
            div_zero_d = 1'b1;
          end else begin
            div_zero_d = 1'b0;
          end
        end
      end
      DIV: begin
        dividend_d = {dividend_q[ITER-2:0], 1'b0};
        rem_d      = rem_new;
        quo_d      = quo_new[ITER-2:0];
        iter_d     = iter_q + ITW'(1);
        if (last_iter) begin
          out_vec_d[elem_q*OUT_W +: OUT_W] = lane_val;
          if (last_elem) begin
            out_valid_d = 1'b1;
          end else begin
            // Next lane starts on the following edge, no idle cycle between lanes.
            elem_d     = elem_inc;
            iter_d     = '0;
            rem_d      = '0;
            quo_d      = '0;
            dividend_d = {vec_lane[elem_inc], {FRAC_BITS{1'b0}}};
          end
        end
      end
      DONE: begin
        // A zero-sum result enters DONE with out_valid low and raises it one cycle later.
        out_valid_d = !(out_valid_q && bus.out_ready);
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_softmax_norm.sv
// Directed scoreboard bench for softmax_norm at default parameters.
module tb_softmax_norm;
  logic clk = 1'b0;
  logic rst;

  softmax_norm_if #(.NUM_INPUTS(4), .DATA_WIDTH(16), .FRAC_BITS(15)) bus_if ();

  softmax_norm #(.NUM_INPUTS(4), .DATA_WIDTH(16), .FRAC_BITS(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] vec;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

`ifdef SOFTMAX_NORM_ROUND_EN
  localparam logic [15:0] THIRD = 16'd10923;
`else
  localparam logic [15:0] THIRD = 16'd10922;
`endif

  function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && bus_if.out_valid && bus_if.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_vec", bus_if.out_vec, e.vec);
        check("div_zero", {63'd0, bus_if.div_zero}, {63'd0, e.dz});
      end
    end
  end

  task automatic send(input logic [63:0] v, input logic [15:0] s, input bit push,
                      input logic [63:0] ev, input bit edz);
    int n;
    exp_t e;
    n = 0;
    while (!bus_if.in_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (!bus_if.in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    bus_if.in_vec   = v;
    bus_if.in_sum   = s;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      e.vec = ev;
      e.dz  = edz;
      sb_q.push_back(e);
    end
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_vec   = 64'hDEAD_BEEF_CAFE_F00D;
    bus_if.in_sum   = 16'h1234;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus_if.out_valid && n < 1000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_vec    = '0;
    bus_if.in_sum    = '0;
    bus_if.out_ready = 1'b1;
    #2;
    check("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("rst_out_vec", bus_if.out_vec, 64'd0);
    check("rst_div_zero", {63'd0, bus_if.div_zero}, 64'd0);
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(2);

    send(pack4(1, 1, 1, 1), 16'd4, 1'b1, pack4(8192, 8192, 8192, 8192), 1'b0);
    wait_valid(lat);
    check("lat_uniform", 64'(lat), 64'd124);
    idle_cycles(3);

    send(pack4(4, 0, 0, 0), 16'd4, 1'b1, pack4(32768, 0, 0, 0), 1'b0);
    wait_valid(lat);
    idle_cycles(3);

    send(pack4(1, 0, 0, 0), 16'd3, 1'b1, pack4(THIRD, 0, 0, 0), 1'b0);
    wait_valid(lat);
    idle_cycles(3);

    send(pack4(5, 0, 0, 0), 16'd2, 1'b1, pack4(65535, 0, 0, 0), 1'b0);
    wait_valid(lat);
    idle_cycles(3);

    send(pack4(7, 3, 9, 1), 16'd0, 1'b1, 64'd0, 1'b1);
    wait_valid(lat);
    check("lat_zero_sum", 64'(lat), 64'd1);
    idle_cycles(3);

    // Backpressure, with a competing input offered during DIV.
    bus_if.out_ready = 1'b0;
    send(pack4(1, 1, 1, 1), 16'd4, 1'b1, pack4(8192, 8192, 8192, 8192), 1'b0);
    bus_if.in_vec   = pack4(4, 0, 0, 0);
    bus_if.in_sum   = 16'd4;
    bus_if.in_valid = 1'b1;
    idle_cycles(5);
    check("div_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
    idle_cycles(15);
    bus_if.in_valid = 1'b0;
    wait_valid(lat);
    check("lat_bp", 64'(lat), 64'd104);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_vec", bus_if.out_vec, pack4(8192, 8192, 8192, 8192));
      check("bp_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, bus_if.out_valid}, 64'd1);
      @(posedge clk); #1;
    end
    check("bp_div_zero", {63'd0, bus_if.div_zero}, 64'd0);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("bp_release_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    idle_cycles(3);
    check("ignored_input_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

    // Abort a transaction mid-division.
    send(pack4(1, 1, 1, 1), 16'd4, 1'b0, 64'd0, 1'b0);
    idle_cycles(49);
    rst = 1'b1;
    #1;
    check("abort_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    check("abort_out_vec", bus_if.out_vec, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    send(pack4(2, 2, 0, 0), 16'd4, 1'b1, pack4(16384, 16384, 0, 0), 1'b0);
    wait_valid(lat);
    check("lat_after_abort", 64'(lat), 64'd124);
    idle_cycles(5);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
